fir_decim_fifo: RTL and testbench

FIR_DECIM_FIFO -- requirements
Module: fir_decim_fifo

---
 rtl/fir_decim_fifo.sv | 99 +++++++++
 tb/tb_fir_decim_fifo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fir_decim_fifo.sv
// fir_decim_fifo: keeps every DECIM-th valid sample from the upstream FIR and
// buffers the kept samples in a first-word-fall-through FIFO with a sticky
// overflow flag for kept samples that found the FIFO full.

`ifndef WIDTH
// Fallback sample width when the project-wide defines have not been included.
`define WIDTH 16
`endif

module fir_decim_fifo #(
  parameter int WIDTH = `WIDTH,
  parameter int DECIM = 4,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           sig_in,
  input  logic                       in_vld,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       ovf_clr,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  // A one-bit phase register keeps the DECIM=1 case legal; it simply never leaves 0.
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic [PW-1:0]    phase;

  logic full;
  logic keep;
  logic pop;
  logic push;
  logic drop;

  assign full      = (count == LW'(DEPTH));
  assign out_valid = (count != '0);
  assign keep      = in_vld && (phase == '0);
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push      = keep && (!full || pop);
  assign drop      = keep && full && !pop;

  // Head of the FIFO is visible directly; forced to zero when empty so reset shows 0.
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign level     = count;

  // Decimation phase: advances on every valid sample, kept or dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of the order the blocks are evaluated.
    if (!rst_n) begin
      phase <= '0;
    end else if (in_vld) begin
      if (phase == PW'(DECIM - 1)) phase <= '0;
      else                         phase <= phase + PW'(1);
    end
  end

  // Sample storage: written on push only.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; occupancy is tracked by
    // count, so stale words are never observed and the array can map to RAM.
    if (rst_n && push) mem[wr_ptr] <= sig_in;
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: a new drop takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Testbench for fir_decim_fifo: directed scenarios plus randomized traffic,
// checked against a queue-based reference model through a scoreboard monitor.

module tb_fir_decim_fifo;

  localparam int WIDTH = 16;
  localparam int DECIM = 4;
  localparam int DEPTH = 8;

  logic                   clk;
  logic                   rst_n;
  logic [WIDTH-1:0]       sig_in;
  logic                   in_vld;
  logic [WIDTH-1:0]       out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   ovf_clr;
  logic                   overflow;
  logic [$clog2(DEPTH):0] level;

  fir_decim_fifo #(.WIDTH(WIDTH), .DECIM(DECIM), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .in_vld    (in_vld),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf_clr   (ovf_clr),
    .overflow  (overflow),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: stored samples in arrival order, valid-sample count
  // since reset, and the expected sticky overflow flag.
  logic [WIDTH-1:0] exp_q[$];
  int               vcount;
  logic             ovf_m;

  int checks;
  int errors;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: on each edge out of reset, every DECIM-th valid sample is kept and
  // stored if there is room; exp_q already excludes the entry popped on this edge.
  always @(posedge clk) begin
    if (rst_n) begin
      logic dropped;
      dropped = 1'b0;
      if (in_vld) begin
        if (vcount % DECIM == 0) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(sig_in);
          else                      dropped = 1'b1;
        end
        vcount++;
      end
      if (dropped)      ovf_m = 1'b1;
      else if (ovf_clr) ovf_m = 1'b0;
    end
  end

  // Monitor: mid-cycle, compare DUT outputs with the model and retire the head
  // when the consumer is accepting it on the coming edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("level", 32'(level), 32'(exp_q.size()));
      check("overflow", 32'(overflow), 32'(ovf_m));
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("out_data", 32'(out_data), 32'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Drive one cycle of inputs, then advance past the next rising edge.
  task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic c);
    in_vld    = v;
    sig_in    = d;
    out_ready = r;
    ovf_clr   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    vcount = 0;
    ovf_m  = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, 16'hdead, 1'b1, 1'b0);
    rst_n = 1'b1;
  endtask

  logic [WIDTH-1:0] d;
  int guard;

  initial begin
    checks = 0;
    errors = 0;
    in_vld = 1'b0;
    sig_in = '0;
    out_ready = 1'b0;
    ovf_clr = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    vcount = 0;
    ovf_m = 1'b0;
    #2;
    do_reset();

    // Continuous valid samples 1..12, consumer always ready: expect 1,5,9.
    for (int i = 1; i <= 12; i++) cyc(1'b1, 16'(i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0);

    // Alternating valid: only valid samples advance the phase.
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1'(i % 2 == 0), 16'(10 + i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0);

    // Consumer stalled for 36 valid samples: 9 kept, the 9th dropped.
    do_reset();
    for (int i = 0; i < 36; i++) cyc(1'b1, 16'(100 + i), 1'b0, 1'b0);
    check("stall_level", 32'(level), 32'd8);
    check("stall_overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    check("drain_empty", 32'(out_valid), 32'd0);

    // Clear overflow with no concurrent drop.
    cyc(1'b0, '0, 1'b0, 1'b1);
    check("ovf_clr", 32'(overflow), 32'd0);

    // Fill to full, then a kept sample arrives on the same edge as a pop.
    d = 16'h0200;
    guard = 0;
    while (!(exp_q.size() == DEPTH && vcount % DECIM == 0) && guard < 200) begin
      cyc(1'b1, d, 1'b0, 1'b0);
      d++;
      guard++;
    end
    check("fill_guard", 32'(guard < 200), 32'd1);
    cyc(1'b1, 16'h0bee, 1'b1, 1'b0);
    check("full_push_pop_level", 32'(level), 32'd8);
    check("full_push_pop_ovf", 32'(overflow), 32'd0);

    // Advance to the next kept sample while stalled, then drop it alongside a clear.
    guard = 0;
    while (vcount % DECIM != 0 && guard < 20) begin
      cyc(1'b1, d, 1'b0, 1'b0);
      d++;
      guard++;
    end
    cyc(1'b1, 16'h0bad, 1'b0, 1'b1);
    check("clr_vs_drop", 32'(overflow), 32'd1);
    for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b1, 1'b0);

    // Mid-operation reset with level 5 and phase 2.
    do_reset();
    for (int i = 0; i < 18; i++) cyc(1'b1, 16'(300 + i), 1'b0, 1'b0);
    check("pre_rst_level", 32'(level), 32'd5);
    do_reset();
    cyc(1'b1, 16'h0777, 1'b1, 1'b0);
    check("post_rst_keep", 32'(out_data), 32'h0777);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 9) < 7), 16'($urandom), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 7) == 0));
    end
    for (int i = 0; i < 12; i++) cyc(1'b0, '0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
